// File: rtl/cr_kme_drbg_pkg.sv
// Shared types and default widths for the KME DRBG seed manager.
// seed_t is the view of one software-programmed seed slot.
package cr_kme_drbg_pkg;

   localparam int RESEED_W_DEF = 48;
   localparam int KEY_W_DEF    = 256;
   localparam int VAL_W_DEF    = 128;

   typedef enum logic [1:0] {
      ST_SELECT = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_EXPIRE = 2'd3
   } state_e;

   typedef struct packed {
      logic                    valid;
      logic [KEY_W_DEF-1:0]    key;
      logic [VAL_W_DEF-1:0]    value;
      logic [RESEED_W_DEF-1:0] interval;
   } seed_t;

endpackage

// File: rtl/cr_kme_drbg_seed_mgr_if.sv
// Seed manager bus: two seed slots from the register block, DRBG load handshake,
// generate permission and status. master = seed manager, slave = its environment.
interface cr_kme_drbg_seed_mgr_if
   import cr_kme_drbg_pkg::*;
#(
   parameter int KEY_W    = KEY_W_DEF,
   parameter int VAL_W    = VAL_W_DEF,
   parameter int RESEED_W = RESEED_W_DEF
);
   logic                seed0_valid;
   logic [KEY_W-1:0]    seed0_internal_state_key;
   logic [VAL_W-1:0]    seed0_internal_state_value;
   logic [RESEED_W-1:0] seed0_reseed_interval;
   logic                seed1_valid;
   logic [KEY_W-1:0]    seed1_internal_state_key;
   logic [VAL_W-1:0]    seed1_internal_state_value;
   logic [RESEED_W-1:0] seed1_reseed_interval;
   logic                seed0_invalidate;
   logic                seed1_invalidate;
   logic                seed_load_valid;
   logic                seed_load_ready;
   logic [KEY_W-1:0]    seed_load_key;
   logic [VAL_W-1:0]    seed_load_value;
   logic                gen_req;
   logic                gen_ack;
   logic                seed_active;
   logic                active_seed_id;
   logic                seed_flush;

   modport master (
      input  seed0_valid, seed0_internal_state_key, seed0_internal_state_value, seed0_reseed_interval,
      input  seed1_valid, seed1_internal_state_key, seed1_internal_state_value, seed1_reseed_interval,
      input  seed_load_ready, gen_req,
      output seed0_invalidate, seed1_invalidate, seed_load_valid, seed_load_key, seed_load_value,
      output gen_ack, seed_active, active_seed_id, seed_flush
   );

   modport slave (
      output seed0_valid, seed0_internal_state_key, seed0_internal_state_value, seed0_reseed_interval,
      output seed1_valid, seed1_internal_state_key, seed1_internal_state_value, seed1_reseed_interval,
      output seed_load_ready, gen_req,
      input  seed0_invalidate, seed1_invalidate, seed_load_valid, seed_load_key, seed_load_value,
      input  gen_ack, seed_active, active_seed_id, seed_flush
   );
endinterface

// File: rtl/cr_kme_drbg_reseed_ctr.sv
// Generate counter for the active seed; o_expire flags the grant that reaches the interval.
// Equality compare only: expiry always precedes wrap.
module cr_kme_drbg_reseed_ctr #(
   parameter int W = 48
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_inc,
   input  logic [W-1:0] i_interval,
   output logic         o_expire,
   output logic         o_int_zero
);
   logic [W-1:0] r_cnt;
   logic [W-1:0] w_next;

   assign w_next     = r_cnt + 1'b1;
   assign o_expire   = i_inc && (w_next == i_interval);
   assign o_int_zero = (i_interval == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= w_next;
      end
   end
endmodule

// File: rtl/cr_kme_drbg_seed_mgr.sv
// Picks a valid seed slot, loads it into the DRBG engine, meters generates against its
// reseed interval and fails over to the other slot on expiry or software withdrawal.
module cr_kme_drbg_seed_mgr
   import cr_kme_drbg_pkg::*;
#(
   parameter int RESEED_W = RESEED_W_DEF,
   parameter int KEY_W    = KEY_W_DEF,
   parameter int VAL_W    = VAL_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   cr_kme_drbg_seed_mgr_if.master bus
);
   state_e              r_state;
   logic                r_pref;
   logic                r_id;
   logic                r_load_vld;
   logic                r_active;
   logic                r_inv0;
   logic                r_inv1;
   logic [KEY_W-1:0]    r_key;
   logic [VAL_W-1:0]    r_val;
   logic [RESEED_W-1:0] r_int;

   seed_t w_s0, w_s1, w_pref_s, w_alt_s, w_pick;
   logic  w_pick_id, w_act_vld, w_withdraw, w_grant, w_load_hs, w_clr, w_expire, w_int_zero;

   assign w_s0 = '{valid: bus.seed0_valid, key: bus.seed0_internal_state_key,
                   value: bus.seed0_internal_state_value, interval: bus.seed0_reseed_interval};
   assign w_s1 = '{valid: bus.seed1_valid, key: bus.seed1_internal_state_key,
                   value: bus.seed1_internal_state_value, interval: bus.seed1_reseed_interval};

   assign w_pref_s  = r_pref ? w_s1 : w_s0;
   assign w_alt_s   = r_pref ? w_s0 : w_s1;
   assign w_pick    = w_pref_s.valid ? w_pref_s : w_alt_s;
   assign w_pick_id = w_pref_s.valid ? r_pref : ~r_pref;

   // Software pulling the in-use slot beats any concurrent grant or load handshake.
   assign w_act_vld  = r_id ? bus.seed1_valid : bus.seed0_valid;
   assign w_withdraw = ((r_state == ST_LOAD) || (r_state == ST_ACTIVE)) && !w_act_vld;
   assign w_grant    = (r_state == ST_ACTIVE) && bus.gen_req && !w_withdraw;
   assign w_load_hs  = (r_state == ST_LOAD) && r_load_vld && bus.seed_load_ready && !w_withdraw;
   assign w_clr      = (r_state == ST_SELECT) && w_pick.valid;

   cr_kme_drbg_reseed_ctr #(.W(RESEED_W)) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_clr),
      .i_inc      (w_grant),
      .i_interval (r_int),
      .o_expire   (w_expire),
      .o_int_zero (w_int_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_SELECT;
         r_pref     <= 1'b0;
         r_id       <= 1'b0;
         r_load_vld <= 1'b0;
         r_active   <= 1'b0;
         r_inv0     <= 1'b0;
         r_inv1     <= 1'b0;
         r_key      <= '0;
         r_val      <= '0;
         r_int      <= '0;
      end else begin
         r_inv0 <= 1'b0;
         r_inv1 <= 1'b0;
         case (r_state)
            ST_SELECT: begin
               if (w_pick.valid) begin
                  r_key      <= w_pick.key;
                  r_val      <= w_pick.value;
                  r_int      <= w_pick.interval;
                  r_id       <= w_pick_id;
                  r_load_vld <= 1'b1;
                  r_state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_withdraw) begin
                  r_load_vld <= 1'b0;
                  r_state    <= ST_SELECT;
               end else if (w_load_hs) begin
                  r_load_vld <= 1'b0;
                  if (w_int_zero) begin
                     r_inv0  <= ~r_id;
                     r_inv1  <= r_id;
                     r_state <= ST_EXPIRE;
                  end else begin
                     r_active <= 1'b1;
                     r_state  <= ST_ACTIVE;
                  end
               end
            end
            ST_ACTIVE: begin
               if (w_withdraw) begin
                  r_active <= 1'b0;
                  r_state  <= ST_SELECT;
               end else if (w_expire) begin
                  r_active <= 1'b0;
                  r_inv0   <= ~r_id;
                  r_inv1   <= r_id;
                  r_state  <= ST_EXPIRE;
               end
            end
            ST_EXPIRE: begin
               r_pref  <= ~r_id;
               r_state <= ST_SELECT;
            end
            default: r_state <= ST_SELECT;
         endcase
      end
   end

   assign bus.seed0_invalidate = r_inv0;
   assign bus.seed1_invalidate = r_inv1;
   assign bus.seed_load_valid  = r_load_vld;
   assign bus.seed_load_key    = r_key;
   assign bus.seed_load_value  = r_val;
   assign bus.gen_ack          = w_grant;
   assign bus.seed_active      = r_active;
   assign bus.active_seed_id   = r_id;
   assign bus.seed_flush       = w_withdraw;
endmodule

// File: tb/tb_cr_kme_drbg_seed_mgr.sv
// Directed bench for the DRBG seed manager; upstream register block modelled as
// clearing a slot's valid on the edge after its invalidate pulse.
module tb_cr_kme_drbg_seed_mgr;
   import cr_kme_drbg_pkg::*;

   localparam logic [255:0] K0 = {8{32'hA0A0_0001}};
   localparam logic [255:0] K1 = {8{32'hB1B1_0002}};
   localparam logic [255:0] K2 = {8{32'hC2C2_0003}};
   localparam logic [127:0] V0 = {4{32'h1111_0A0A}};
   localparam logic [127:0] V1 = {4{32'h2222_1B1B}};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cr_kme_drbg_seed_mgr_if bus ();
   cr_kme_drbg_seed_mgr dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   int n_ack, n_ack0, n_ack1, n_inv0, n_inv1, n_both, n_ack_inv, n_flush, n_hs, n_act;
   int cyc_n, last_ack, inv_at;
   bit pend0, pend1, got0, got1;
   logic s_ack, s_flush, s_inv0, s_inv1, s_lvld, s_act, s_id;
   logic [255:0] k0_seen, k1_seen;
   logic [127:0] v1_seen;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic clr_cnt();
      n_ack = 0; n_ack0 = 0; n_ack1 = 0; n_inv0 = 0; n_inv1 = 0; n_both = 0;
      n_ack_inv = 0; n_flush = 0; n_hs = 0; n_act = 0;
      cyc_n = 0; last_ack = -100; inv_at = -50;
      got0 = 0; got1 = 0; s_act = 0; s_lvld = 0;
   endtask

   // Sample mid-cycle, then advance one edge and apply the upstream valid clear.
   task automatic cyc();
      #1;
      s_ack   = bus.gen_ack;
      s_flush = bus.seed_flush;
      s_inv0  = bus.seed0_invalidate;
      s_inv1  = bus.seed1_invalidate;
      s_lvld  = bus.seed_load_valid;
      s_act   = bus.seed_active;
      s_id    = bus.active_seed_id;
      if (s_ack) begin
         n_ack++;
         if (s_id) n_ack1++; else n_ack0++;
         last_ack = cyc_n;
      end
      if (s_inv0) begin n_inv0++; inv_at = cyc_n; pend0 = 1; end
      if (s_inv1) begin n_inv1++; inv_at = cyc_n; pend1 = 1; end
      if (s_inv0 && s_inv1) n_both++;
      if (s_ack && (s_inv0 || s_inv1)) n_ack_inv++;
      if (s_flush) n_flush++;
      if (s_lvld && bus.seed_load_ready) n_hs++;
      if (s_act) n_act++;
      if (s_lvld && !s_id && !got0) begin k0_seen = bus.seed_load_key; got0 = 1; end
      if (s_lvld && s_id && !got1) begin
         k1_seen = bus.seed_load_key; v1_seen = bus.seed_load_value; got1 = 1;
      end
      cyc_n++;
      @(posedge clk);
      #1;
      if (pend0) begin bus.seed0_valid = 1'b0; pend0 = 0; end
      if (pend1) begin bus.seed1_valid = 1'b0; pend1 = 0; end
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic set_slot(input int s, input logic v, input logic [255:0] k,
                           input logic [127:0] val, input logic [47:0] iv);
      if (s == 0) begin
         bus.seed0_valid = v; bus.seed0_internal_state_key = k;
         bus.seed0_internal_state_value = val; bus.seed0_reseed_interval = iv;
      end else begin
         bus.seed1_valid = v; bus.seed1_internal_state_key = k;
         bus.seed1_internal_state_value = val; bus.seed1_reseed_interval = iv;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_slot(0, 1'b0, '0, '0, '0);
      set_slot(1, 1'b0, '0, '0, '0);
      bus.seed_load_ready = 1'b0;
      bus.gen_req = 1'b0;
      pend0 = 0; pend1 = 0;
      run(2);
      rst = 1'b0;
      clr_cnt();
   endtask

   task automatic wait_active(input string tag);
      for (int i = 0; i < 20 && !s_act; i++) cyc();
      chk(tag, 256'(s_act), 256'(1));
   endtask

   initial begin
      rst = 1'b1;
      set_slot(0, 1'b0, '0, '0, '0);
      set_slot(1, 1'b0, '0, '0, '0);
      bus.seed_load_ready = 1'b0;
      bus.gen_req = 1'b1;
      pend0 = 0; pend1 = 0;
      clr_cnt();
      #2;
      chk("rst_load_valid", 256'(bus.seed_load_valid), 256'(0));
      chk("rst_active", 256'(bus.seed_active), 256'(0));
      chk("rst_id", 256'(bus.active_seed_id), 256'(0));
      chk("rst_gen_ack", 256'(bus.gen_ack), 256'(0));
      chk("rst_inv", 256'({bus.seed0_invalidate, bus.seed1_invalidate, bus.seed_flush}), 256'(0));
      chk("rst_key", bus.seed_load_key, 256'(0));
      chk("rst_value", 256'(bus.seed_load_value), 256'(0));

      // Basic expiry: interval 3, ready and gen_req held.
      do_reset();
      set_slot(0, 1'b1, K0, V0, 48'd3);
      bus.seed_load_ready = 1'b1;
      bus.gen_req = 1'b1;
      run(12);
      chk("basic_acks", 256'(n_ack), 256'(3));
      chk("basic_inv0", 256'(n_inv0), 256'(1));
      chk("basic_inv1", 256'(n_inv1), 256'(0));
      chk("basic_inv_after_ack", 256'(inv_at - last_ack), 256'(1));
      chk("basic_no_ack_in_expire", 256'(n_ack_inv), 256'(0));
      chk("basic_load_key", k0_seen, K0);
      chk("basic_idle_active", 256'(bus.seed_active), 256'(0));

      // Failover slot0 (2) -> slot1 (5).
      do_reset();
      set_slot(0, 1'b1, K0, V0, 48'd2);
      set_slot(1, 1'b1, K1, V1, 48'd5);
      bus.seed_load_ready = 1'b1;
      bus.gen_req = 1'b1;
      run(25);
      chk("fo_acks_slot0", 256'(n_ack0), 256'(2));
      chk("fo_acks_slot1", 256'(n_ack1), 256'(5));
      chk("fo_inv0", 256'(n_inv0), 256'(1));
      chk("fo_inv1", 256'(n_inv1), 256'(1));
      chk("fo_inv_both", 256'(n_both), 256'(0));
      chk("fo_key1", k1_seen, K1);
      chk("fo_val1", 256'(v1_seen), 256'(V1));
      chk("fo_last_inv_after_ack", 256'(inv_at - last_ack), 256'(1));

      // Zero interval: load completes then immediate expiry.
      do_reset();
      set_slot(0, 1'b1, K0, V0, 48'd0);
      bus.seed_load_ready = 1'b1;
      bus.gen_req = 1'b1;
      run(10);
      chk("zero_acks", 256'(n_ack), 256'(0));
      chk("zero_inv0", 256'(n_inv0), 256'(1));
      chk("zero_load_hs", 256'(n_hs), 256'(1));
      chk("zero_never_active", 256'(n_act), 256'(0));
      chk("zero_idle_lvld", 256'(bus.seed_load_valid), 256'(0));

      // Backpressure with key rewritten while waiting.
      do_reset();
      set_slot(0, 1'b1, K0, V0, 48'd2);
      bus.seed_load_ready = 1'b0;
      bus.gen_req = 1'b1;
      run(3);
      bus.seed0_internal_state_key = K2;
      run(7);
      chk("bp_lvld_held", 256'(bus.seed_load_valid), 256'(1));
      chk("bp_key_held", bus.seed_load_key, K0);
      chk("bp_no_ack", 256'(n_ack), 256'(0));
      bus.seed_load_ready = 1'b1;
      run(10);
      chk("bp_acks", 256'(n_ack), 256'(2));
      chk("bp_inv0", 256'(n_inv0), 256'(1));
      chk("bp_key_after", bus.seed_load_key, K0);

      // Withdrawal of slot0 coinciding with gen_req.
      do_reset();
      set_slot(0, 1'b1, K0, V0, 48'd4);
      set_slot(1, 1'b1, K1, V1, 48'd3);
      bus.seed_load_ready = 1'b1;
      bus.gen_req = 1'b0;
      wait_active("wd_active");
      bus.gen_req = 1'b1;
      bus.seed0_valid = 1'b0;
      cyc();
      chk("wd_flush", 256'(s_flush), 256'(1));
      chk("wd_no_ack", 256'(s_ack), 256'(0));
      chk("wd_no_inv", 256'({s_inv0, s_inv1}), 256'(0));
      bus.gen_req = 1'b0;
      s_lvld = 0;
      for (int i = 0; i < 10 && !s_lvld; i++) cyc();
      chk("wd_reload", 256'(s_lvld), 256'(1));
      chk("wd_next_id", 256'(s_id), 256'(1));
      chk("wd_next_key", k1_seen, K1);
      chk("wd_flush_once", 256'(n_flush), 256'(1));

      // Async reset in ACTIVE after one of four grants.
      do_reset();
      set_slot(0, 1'b1, K0, V0, 48'd4);
      bus.seed_load_ready = 1'b1;
      bus.gen_req = 1'b0;
      wait_active("rs_active");
      bus.gen_req = 1'b1;
      cyc();
      chk("rs_one_ack", 256'(n_ack), 256'(1));
      rst = 1'b1;
      #1;
      chk("rs_ack_cleared", 256'(bus.gen_ack), 256'(0));
      chk("rs_active_cleared", 256'(bus.seed_active), 256'(0));
      chk("rs_misc_cleared", 256'({bus.seed_load_valid, bus.active_seed_id,
                                    bus.seed0_invalidate, bus.seed1_invalidate, bus.seed_flush}), 256'(0));
      chk("rs_key_cleared", bus.seed_load_key, 256'(0));
      run(2);
      rst = 1'b0;
      clr_cnt();
      run(15);
      chk("rs_acks_after", 256'(n_ack), 256'(4));
      chk("rs_inv0_after", 256'(n_inv0), 256'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cr_kme_drbg_seed_mgr.md
Name: cr_kme_drbg_seed_mgr

Overview:
Consumes the two software-programmed DRBG seed slots from the KME DRBG register block. Selects one valid slot and loads its key/value into the DRBG engine. Counts generate operations against that slot's reseed interval. On expiry it returns a one-cycle invalidate pulse upstream, which clears the slot's valid bit and raises the expired interrupt, then fails over to the other slot.

Parameters:
RESEED_W, 48, width of reseed interval and generate counter
KEY_W, 256, seed key width
VAL_W, 128, seed value width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
seed0_valid  in  1  slot 0 programmed and valid
seed0_internal_state_key  in  KEY_W  slot 0 key
seed0_internal_state_value  in  VAL_W  slot 0 value
seed0_reseed_interval  in  RESEED_W  slot 0 generate budget
seed1_valid / seed1_internal_state_key / seed1_internal_state_value / seed1_reseed_interval  in  1/KEY_W/VAL_W/RESEED_W  slot 1 equivalents
seed0_invalidate  out  1  one-cycle pulse: slot 0 expired
seed1_invalidate  out  1  one-cycle pulse: slot 1 expired
seed_load_valid  out  1  key/value offered to DRBG engine
seed_load_ready  in  1  engine accepts load
seed_load_key  out  KEY_W  captured key
seed_load_value  out  VAL_W  captured value
gen_req  in  1  engine requests permission for one generate (level)
gen_ack  out  1  one-cycle grant of one generate
seed_active  out  1  a loaded seed is in use
active_seed_id  out  1  slot in use
seed_flush  out  1  one-cycle pulse: active seed withdrawn by software

Behaviour:
- Reset values:
  - State: SELECT.
  - All pulses, seed_load_valid, seed_active, active_seed_id, counter, captured interval/key/value: 0.
  - pref (preferred slot register): 0.
- FSM states: SELECT, LOAD, ACTIVE, EXPIRE.
- SELECT:
  - If seed[pref]_valid, choose pref. Else if seed[~pref]_valid, choose ~pref. Else stay in SELECT.
  - On a choice: capture key, value and interval of the chosen slot; set active_seed_id; clear counter; go to LOAD.
- LOAD:
  - seed_load_valid=1; key/value held stable from the captured registers.
  - On seed_load_valid & seed_load_ready: if captured interval==0, go to EXPIRE; else go to ACTIVE with seed_active=1.
- ACTIVE:
  - gen_ack = gen_req for one cycle per grant. Back-to-back grants are allowed, one per cycle.
  - Counter increments on each gen_ack.
  - When a grant makes counter == interval, the next state is EXPIRE.
- EXPIRE:
  - seedN_invalidate=1 for exactly one cycle (N = active_seed_id); seed_active=0.
  - pref <= ~active_seed_id; next state SELECT.
  - Upstream valid drops on the following edge, so SELECT never reselects the expired slot unless software rewrote it.
- Software withdrawal: if the active slot's valid falls in LOAD or ACTIVE:
  - seed_flush pulses for one cycle; no invalidate; no gen_ack in that cycle.
  - seed_load_valid drops; next state SELECT; pref unchanged.
  - Withdrawal takes priority over a simultaneous gen_req or seed_load_ready.
- Interval, key and value changes while a slot is in use are ignored; the captured copies are authoritative.
- Counter is RESEED_W bits, compared for equality only, and never wraps (expiry precedes overflow).
- gen_ack never asserts outside ACTIVE. Invalidate pulses are never simultaneous for both slots.
- Reset mid-operation: immediate return to reset values. Any pending load or grant is dropped.

Decomposition:
- Package cr_kme_drbg_pkg:
  - FSM state enum.
  - Localparams for KEY_W, VAL_W and RESEED_W defaults.
  - seed_t struct {valid, key, value, interval}.
- Sub-module cr_kme_drbg_reseed_ctr: counter with clear, increment, captured-interval compare, and an expire output. Holds a 48-bit register plus comparator.

Test Plan:
- Basic expiry: slot0 valid, interval=3, load ready immediate, gen_req held high:
  - exactly 3 gen_ack pulses;
  - seed0_invalidate high one cycle after the third;
  - no grant in EXPIRE.
- Failover: both slots valid, slot0 interval=2, slot1 interval=5. After slot0 expires:
  - active_seed_id=1;
  - slot1 key/value presented on seed_load_*;
  - 5 acks, then seed1_invalidate.
- Zero interval: slot0 interval=0, slot1 invalid:
  - load completes, seed0_invalidate pulses, zero gen_ack;
  - FSM idles in SELECT.
- Backpressure: seed_load_ready low 10 cycles, seed0 key changed mid-wait:
  - seed_load_key stays at the originally captured value;
  - no gen_ack until ready.
- Withdrawal: in ACTIVE, slot0_valid falls in the same cycle as gen_req:
  - seed_flush=1, gen_ack=0, no invalidate;
  - slot1 (valid) is selected next.
- Async reset asserted in ACTIVE after 1 of 4 grants:
  - all outputs 0 immediately;
  - after release, slot0 reloads and the counter restarts from 0 (4 more acks before expiry).
